// File: rtl/stepper_seq_ctrl.sv
// 4-coil stepper sequencer: full/half-step phase table driven at a programmable
// step period, with start/busy/done handshake, abort, coil hold and position retention.
module stepper_seq_ctrl #(
    parameter int STEP_W = 16,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir,
    input  logic              half_step,
    input  logic [STEP_W-1:0] steps,
    input  logic [DIV_W-1:0]  period,
    input  logic              abort,
    input  logic              hold,
    output logic [3:0]        coils,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] step_pos
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_W-1:0]  DIV_ONE  = 1;
    localparam logic [STEP_W-1:0] STEP_ONE = 1;

    state_t            state_q;
    logic [2:0]        idx_q;
    logic [3:0]        coils_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;
    logic [STEP_W-1:0] step_pos_q;
    logic              dir_q;
    logic              half_q;
    logic [STEP_W-1:0] steps_q;
    logic [DIV_W-1:0]  period_q;
    logic [DIV_W-1:0]  presc_q;

    logic [2:0]        idx_base_d;
    logic [2:0]        idx_d;
    logic [STEP_W-1:0] step_pos_d;
    logic              tick_d;
    logic              last_d;

    function automatic logic [3:0] phase_pat(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0011;
            3'd1:    p = 4'b0010;
            3'd2:    p = 4'b0110;
            3'd3:    p = 4'b0100;
            3'd4:    p = 4'b1100;
            3'd5:    p = 4'b1000;
            3'd6:    p = 4'b1001;
            default: p = 4'b0001;
        endcase
        return p;
    endfunction

    // Full-step drops bit0 first so an odd phase lands back on the even grid.
    always_comb begin
        idx_base_d = half_q ? idx_q : {idx_q[2:1], 1'b0};
        if (dir_q) begin
            idx_d = idx_base_d + (half_q ? 3'd1 : 3'd2);
        end else begin
            idx_d = idx_base_d - (half_q ? 3'd1 : 3'd2);
        end
        step_pos_d = step_pos_q + STEP_ONE;
        tick_d     = (presc_q == (period_q - DIV_ONE));
        last_d     = (step_pos_d == steps_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            coils_q    <= 4'b0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            step_pos_q <= '0;
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            steps_q    <= '0;
            period_q   <= '0;
            presc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dir_q      <= dir;
                        half_q     <= half_step;
                        steps_q    <= steps;
                        period_q   <= (period == '0) ? DIV_ONE : period;
                        step_pos_q <= '0;
                        aborted_q  <= 1'b0;
                        presc_q    <= '0;
                        coils_q    <= phase_pat(idx_q);
                        if (steps == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        coils_q <= hold ? phase_pat(idx_q) : 4'b0000;
                    end
                end
                RUN: begin
                    // Abort takes priority over a coinciding tick so step_pos freezes.
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (tick_d) begin
                        presc_q    <= '0;
                        idx_q      <= idx_d;
                        coils_q    <= phase_pat(idx_d);
                        step_pos_q <= step_pos_d;
                        if (last_d) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q + DIV_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coils    = coils_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign step_pos = step_pos_q;

endmodule
